pll_drp_sequencer: RTL and testbench
====================================

Name: pll_drp_sequencer

Overview:
- Reconfiguration controller for the PLL/MMCM simulation models; drives their dynamic reconfiguration (DRP) ports from DCLK.
- Accepts a stream of (address, mask, data) entries and holds the PLL in reset while it applies them.
- Performs a read-modify-write per entry, then releases reset and waits for LOCKED.
- Sits between a host/config FSM and one PLLE2_ADV/MMCM instance; the only writer of its DRP and RST pins.

Parameters:
- DRDY_TIMEOUT, 64: max DCLK cycles from a DEN pulse to DRDY; 1..65535.
- LOCK_TIMEOUT, 4096: max DCLK cycles from PLL_RST release to PLL_LOCKED; 1..65535.
- RST_HOLD, 4: cycles PLL_RST stays high before the first DRP access; >=1.

Ports:
- DCLK in 1: single clock; all logic on rising edge.
- RST_N in 1: synchronous, active-low reset.
- START in 1: begin sequence; sampled only in IDLE.
- BUSY out 1: high in every state except IDLE.
- DONE out 1: one-cycle pulse on successful lock.
- ERROR out 1: sticky; cleared on next accepted START or reset.
- ERR_CODE out 2: 0 none, 1 DRDY timeout, 2 lock timeout, 3 verify mismatch.
- ENT_VALID in 1: entry available.
- ENT_READY out 1: entry accepted this cycle when ENT_VALID && ENT_READY.
- ENT_ADDR in 7: DRP address.
- ENT_MASK in 16: 1 = bit replaced from ENT_DATA; 0 = bit kept from readback.
- ENT_DATA in 16: new bit values.
- ENT_LAST in 1: final entry of the sequence.
- PLL_DADDR out 7, PLL_DI out 16, PLL_DEN out 1, PLL_DWE out 1: to PLL DADDR/DI/DEN/DWE.
- PLL_DO in 16, PLL_DRDY in 1: from PLL DO/DRDY.
- PLL_RST out 1, PLL_LOCKED in 1: to PLL RST, from PLL LOCKED.

Behaviour:
- Reset values (RST_N low at an edge): state IDLE; BUSY, DONE, ERROR, ENT_READY, PLL_DEN, PLL_DWE = 0; ERR_CODE = 0; PLL_DADDR, PLL_DI = 0; PLL_RST = 1 (PLL held in reset until first sequence).
- Reset mid-sequence aborts immediately; any DRDY still outstanding is ignored.
- IDLE: PLL_RST mirrors "never locked" (1 until the first DONE, then 0).
  - START=1 -> HOLD; clears ERROR/ERR_CODE; loads the hold counter with RST_HOLD.
- HOLD: PLL_RST=1; counter decrements; at 0 -> FETCH.
- FETCH: ENT_READY=1.
  - On handshake, latch addr/mask/data/last -> RD_REQ.
  - ENT_READY is only high in FETCH.
- RD_REQ: PLL_DEN=1 and PLL_DWE=0 for exactly one cycle, PLL_DADDR = latched addr -> RD_WAIT; load the timeout counter.
- RD_WAIT:
  - On PLL_DRDY: compute word = (PLL_DO & ~mask) | (data & mask) -> WR_REQ.
  - On counter expiry before DRDY -> ERR (code 1).
- WR_REQ: PLL_DEN=1 and PLL_DWE=1 for one cycle, PLL_DI = word -> WR_WAIT.
- WR_WAIT:
  - On PLL_DRDY: last=1 -> RELEASE; last=0 -> FETCH.
  - On timeout -> ERR (code 1).
- RELEASE: PLL_RST -> 0 registered; load lock counter -> LOCK_WAIT.
- LOCK_WAIT:
  - PLL_LOCKED=1 -> DONE pulse one cycle, state IDLE.
  - Lock timeout -> ERR (code 2).
- ERR: ERROR=1 with code latched; PLL_RST=1; -> IDLE next cycle. START from IDLE retries.
- DRDY outside RD_WAIT/WR_WAIT is ignored.
- DRDY arriving in the same cycle as timeout expiry counts as success.
- Latency: minimum 2 DRP cycles per access (DEN, DRDY next); minimum per entry 5 cycles (FETCH, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT).
- Counters are 16-bit saturating down-counters; never wrap.

Optional Feature:
- Macro PLL_DRP_VERIFY_EN.
- Defined: after WR_WAIT, add VFY_REQ/VFY_WAIT states.
  - Read the same address with a one-cycle DEN.
  - If PLL_DO != written word -> ERR (code 3); else continue as WR_WAIT would.
  - DRDY timeout applies to the verify read.
- Undefined: states absent; code 3 never produced.

Decomposition:
- Package pll_drp_pkg holds:
  - state encoding localparams;
  - ERR_* code constants;
  - DRP address/data width constants (7, 16).
- One sub-module, pll_drp_timer: loadable 16-bit down-counter with an expired flag, instantiated for DRDY and lock timeouts.

Test Plan:
- Single entry addr 0x08, mask 0x0FFF, data 0x0041, DO model returns 0x1C00 -> one write with DI=0x1041, PLL_RST high >=4 cycles then low, DONE pulse after LOCKED.
- Three entries (0x08, 0x09, 0x14, last on 3rd) with ENT_VALID gapped by 3 idle cycles -> exactly 3 read/write pairs in order, ENT_READY high only in FETCH.
- DRDY never returned on read -> ERROR=1, ERR_CODE=1 after 64 cycles, PLL_RST=1, BUSY falls; new START clears ERROR.
- LOCKED held low -> ERR_CODE=2 after 4096 cycles post-release.
- RST_N low during WR_WAIT, then late DRDY -> outputs at reset values, no DONE, DRDY ignored.
- With PLL_DRP_VERIFY_EN, DO model corrupts bit 0 on readback -> ERR_CODE=3; without macro, same run -> DONE.

Source files
------------

// File: rtl/pll_drp_pkg.sv
// Shared constants for the PLL DRP reconfiguration sequencer: widths, error codes, state encoding.
// Verify states exist only when PLL_DRP_VERIFY_EN is defined.
package pll_drp_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;
    localparam int TMR_W  = 16;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_DRDY   = 2'd1;
    localparam logic [1:0] ERR_LOCK   = 2'd2;
    localparam logic [1:0] ERR_VERIFY = 2'd3;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_HOLD      = 4'd1;
    localparam logic [3:0] ST_FETCH     = 4'd2;
    localparam logic [3:0] ST_RD_REQ    = 4'd3;
    localparam logic [3:0] ST_RD_WAIT   = 4'd4;
    localparam logic [3:0] ST_WR_REQ    = 4'd5;
    localparam logic [3:0] ST_WR_WAIT   = 4'd6;
    localparam logic [3:0] ST_RELEASE   = 4'd7;
    localparam logic [3:0] ST_LOCK_WAIT = 4'd8;
    localparam logic [3:0] ST_ERR       = 4'd9;
    localparam logic [3:0] ST_VFY_REQ   = 4'd10;
    localparam logic [3:0] ST_VFY_WAIT  = 4'd11;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_HOLD      = ST_HOLD,
        S_FETCH     = ST_FETCH,
        S_RD_REQ    = ST_RD_REQ,
        S_RD_WAIT   = ST_RD_WAIT,
        S_WR_REQ    = ST_WR_REQ,
        S_WR_WAIT   = ST_WR_WAIT,
        S_RELEASE   = ST_RELEASE,
        S_LOCK_WAIT = ST_LOCK_WAIT,
`ifdef PLL_DRP_VERIFY_EN
        S_VFY_REQ   = ST_VFY_REQ,
        S_VFY_WAIT  = ST_VFY_WAIT,
`endif
        S_ERR       = ST_ERR
    } state_t;

    // Read-modify-write merge: mask bit 1 takes the new data bit.
    function automatic logic [DRP_DW-1:0] rmw_merge(input logic [DRP_DW-1:0] rd,
                                                     input logic [DRP_DW-1:0] mask,
                                                     input logic [DRP_DW-1:0] data);
        return (rd & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/pll_drp_if.sv
// Bundles the entry stream and the PLL DRP/reset pins; master = sequencer, slave = host + PLL.
// Entry handshake: an entry transfers on a rising edge where ent_valid && ent_ready; ent_valid
// and the entry fields must hold steady until that edge, and ent_ready never depends on ent_valid.
interface pll_drp_if;
    import pll_drp_pkg::*;

    logic              ent_valid;
    logic              ent_ready;
    logic [DRP_AW-1:0] ent_addr;
    logic [DRP_DW-1:0] ent_mask;
    logic [DRP_DW-1:0] ent_data;
    logic              ent_last;

    logic [DRP_AW-1:0] pll_daddr;
    logic [DRP_DW-1:0] pll_di;
    logic              pll_den;
    logic              pll_dwe;
    logic [DRP_DW-1:0] pll_do;
    logic              pll_drdy;
    logic              pll_rst;
    logic              pll_locked;

    modport master (
        input  ent_valid, ent_addr, ent_mask, ent_data, ent_last,
        output ent_ready,
        output pll_daddr, pll_di, pll_den, pll_dwe, pll_rst,
        input  pll_do, pll_drdy, pll_locked
    );

    modport slave (
        output ent_valid, ent_addr, ent_mask, ent_data, ent_last,
        input  ent_ready,
        input  pll_daddr, pll_di, pll_den, pll_dwe, pll_rst,
        output pll_do, pll_drdy, pll_locked
    );

endinterface

// File: rtl/pll_drp_timer.sv
// Loadable saturating 16-bit down-counter; expired is high whenever the count has reached zero.
module pll_drp_timer
    import pll_drp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             run,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/pll_drp_sequencer.sv
// Applies (addr, mask, data) read-modify-write entries to a PLL over DRP while holding it in reset,
// then releases reset and waits for lock. Define PLL_DRP_VERIFY_EN to read back each written word.
module pll_drp_sequencer
    import pll_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int RST_HOLD     = 4
) (
    input  logic       dclk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output state_t     dbg_state,
    pll_drp_if.master  bus
);

    state_t            state, next_state;
    logic [TMR_W-1:0]  hold_cnt;
    logic [DRP_AW-1:0] addr_q;
    logic [DRP_DW-1:0] mask_q, data_q, word_q;
    logic              last_q;
    logic              done_q, error_q, pll_rst_q, ever_locked;
    logic [1:0]        err_code_q;

    logic              err_set, ent_take, word_take;
    logic [1:0]        err_val;
    logic              drdy_load, drdy_run, drdy_expired;
    logic              lock_load, lock_run, lock_expired;
    logic              locked_now;

    pll_drp_timer u_drdy_timer (
        .clk      (dclk),
        .rst_n    (rst_n),
        .load     (drdy_load),
        .load_val (TMR_W'(DRDY_TIMEOUT)),
        .run      (drdy_run),
        .expired  (drdy_expired)
    );

    pll_drp_timer u_lock_timer (
        .clk      (dclk),
        .rst_n    (rst_n),
        .load     (lock_load),
        .load_val (TMR_W'(LOCK_TIMEOUT)),
        .run      (lock_run),
        .expired  (lock_expired)
    );

    assign locked_now = (state == S_LOCK_WAIT) && bus.pll_locked;

    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        err_val    = ERR_NONE;
        ent_take   = 1'b0;
        word_take  = 1'b0;
        drdy_load  = 1'b0;
        drdy_run   = 1'b0;
        lock_load  = 1'b0;
        lock_run   = 1'b0;
        case (state)
            S_IDLE:  if (start) next_state = S_HOLD;
            S_HOLD:  if (hold_cnt <= TMR_W'(1)) next_state = S_FETCH;
            S_FETCH: begin
                if (bus.ent_valid) begin
                    ent_take   = 1'b1;
                    next_state = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                drdy_load  = 1'b1;
                next_state = S_RD_WAIT;
            end
            // DRDY is checked before expiry so a same-cycle DRDY still succeeds.
            S_RD_WAIT: begin
                drdy_run = 1'b1;
                if (bus.pll_drdy) begin
                    word_take  = 1'b1;
                    next_state = S_WR_REQ;
                end else if (drdy_expired) begin
                    err_set    = 1'b1;
                    err_val    = ERR_DRDY;
                    next_state = S_ERR;
                end
            end
            S_WR_REQ: begin
                drdy_load  = 1'b1;
                next_state = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                drdy_run = 1'b1;
                if (bus.pll_drdy) begin
`ifdef PLL_DRP_VERIFY_EN
                    next_state = S_VFY_REQ;
`else
                    next_state = last_q ? S_RELEASE : S_FETCH;
`endif
                end else if (drdy_expired) begin
                    err_set    = 1'b1;
                    err_val    = ERR_DRDY;
                    next_state = S_ERR;
                end
            end
`ifdef PLL_DRP_VERIFY_EN
            S_VFY_REQ: begin
                drdy_load  = 1'b1;
                next_state = S_VFY_WAIT;
            end
            S_VFY_WAIT: begin
                drdy_run = 1'b1;
                if (bus.pll_drdy) begin
                    if (bus.pll_do != word_q) begin
                        err_set    = 1'b1;
                        err_val    = ERR_VERIFY;
                        next_state = S_ERR;
                    end else begin
                        next_state = last_q ? S_RELEASE : S_FETCH;
                    end
                end else if (drdy_expired) begin
                    err_set    = 1'b1;
                    err_val    = ERR_DRDY;
                    next_state = S_ERR;
                end
            end
`endif
            S_RELEASE: begin
                lock_load  = 1'b1;
                next_state = S_LOCK_WAIT;
            end
            S_LOCK_WAIT: begin
                lock_run = 1'b1;
                if (bus.pll_locked) begin
                    next_state = S_IDLE;
                end else if (lock_expired) begin
                    err_set    = 1'b1;
                    err_val    = ERR_LOCK;
                    next_state = S_ERR;
                end
            end
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            pll_rst_q   <= 1'b1;
            ever_locked <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= locked_now;
            if (locked_now) ever_locked <= 1'b1;

            if ((state == S_IDLE) && start) begin
                error_q    <= 1'b0;
                err_code_q <= ERR_NONE;
                hold_cnt   <= TMR_W'(RST_HOLD);
            end else if ((state == S_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - 1'b1;
            end

            if (err_set) begin
                error_q    <= 1'b1;
                err_code_q <= err_val;
            end

            if (ent_take) begin
                addr_q <= bus.ent_addr;
                mask_q <= bus.ent_mask;
                data_q <= bus.ent_data;
                last_q <= bus.ent_last;
            end

            if (word_take) word_q <= rmw_merge(bus.pll_do, mask_q, data_q);

            // Reset is released only for the lock wait; IDLE keeps it asserted until a first lock.
            case (next_state)
                S_LOCK_WAIT: pll_rst_q <= 1'b0;
                S_IDLE:      pll_rst_q <= ~(ever_locked | locked_now);
                default:     pll_rst_q <= 1'b1;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign dbg_state     = state;
    assign bus.ent_ready = (state == S_FETCH);
    assign bus.pll_den   = (state == S_RD_REQ) || (state == S_WR_REQ)
`ifdef PLL_DRP_VERIFY_EN
                           || (state == S_VFY_REQ)
`endif
                           ;
    assign bus.pll_dwe   = (state == S_WR_REQ);
    assign bus.pll_daddr = addr_q;
    assign bus.pll_di    = word_q;
    assign bus.pll_rst   = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Directed bench for pll_drp_sequencer with a DRP register-file model and a LOCKED model.
// Expected verify behaviour follows PLL_DRP_VERIFY_EN.
module tb_pll_drp_sequencer;
    import pll_drp_pkg::*;

    logic       dclk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, error;
    logic [1:0] err_code;
    state_t     dbg_state;

    pll_drp_if bus ();

    pll_drp_sequencer #(
        .DRDY_TIMEOUT (64),
        .LOCK_TIMEOUT (4096),
        .RST_HOLD     (4)
    ) dut (
        .dclk      (dclk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .dbg_state (dbg_state),
        .bus       (bus.master)
    );

    // ---------------- clock ----------------
    always #5 dclk = ~dclk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [22:0] exp_q[$];
    logic [22:0] wr_q[$];
    int rd_count = 0;

    // ---------------- PLL models ----------------
    logic [15:0] mem [128];
    int          drp_mode = 0;      // 0 answer all, 1 answer none, 2 answer reads only
    bit          corrupt = 1'b0;    // flip bit 0 of read data
    bit          inject_drdy = 1'b0;
    bit          lock_en = 1'b1;
    bit          pre_en = 1'b0;
    logic [6:0]  pre_addr;
    logic [15:0] pre_val;
    int          lock_cnt = 0;

    always @(posedge dclk) begin
        bus.pll_drdy <= inject_drdy;
        if (pre_en) mem[pre_addr] = pre_val;
        if (bus.pll_den) begin
            if (bus.pll_dwe) begin
                mem[bus.pll_daddr] = bus.pll_di;
                wr_q.push_back({bus.pll_daddr, bus.pll_di});
                if (drp_mode == 0) bus.pll_drdy <= 1'b1;
            end else begin
                rd_count = rd_count + 1;
                bus.pll_do <= mem[bus.pll_daddr] ^ {15'd0, corrupt};
                if (drp_mode != 1) bus.pll_drdy <= 1'b1;
            end
        end
    end

    always @(posedge dclk) begin
        if (bus.pll_rst || !lock_en) begin
            lock_cnt <= 0;
            bus.pll_locked <= 1'b0;
        end else if (lock_cnt < 3) begin
            lock_cnt <= lock_cnt + 1;
        end else begin
            bus.pll_locked <= 1'b1;
        end
    end

    // ---------------- driver ----------------
    logic [6:0]  tab_addr [4];
    logic [15:0] tab_mask [4];
    logic [15:0] tab_data [4];

    bit   sq_done, sq_err;
    logic sq_err_at_start;
    int   sq_rst_hold, sq_den_cyc, sq_rel_cyc, sq_err_cyc, sq_ready_viol;

    task automatic preload(input logic [6:0] a, input logic [15:0] v);
        @(negedge dclk);
        pre_addr = a;
        pre_val  = v;
        pre_en   = 1'b1;
        @(negedge dclk);
        pre_en   = 1'b0;
    endtask

    // Pulses start, feeds n table entries with gap idle cycles between them, stops on DONE/ERROR.
    task automatic run_seq(input int n, input int gap, input int budget);
        int  idx, gap_cnt;
        bit  pending, seen_den;
        sq_done = 0; sq_err = 0; sq_rst_hold = 0; sq_den_cyc = -1;
        sq_rel_cyc = -1; sq_err_cyc = -1; sq_ready_viol = 0;
        idx = 0; gap_cnt = 0; pending = 0; seen_den = 0;
        @(negedge dclk);
        start = 1'b1;
        @(negedge dclk);
        start = 1'b0;
        sq_err_at_start = error;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (pending) begin
                idx++;
                bus.ent_valid = 1'b0;
                pending = 0;
                gap_cnt = gap;
            end
            if (!bus.ent_valid && idx < n) begin
                if (gap_cnt == 0) begin
                    bus.ent_valid = 1'b1;
                    bus.ent_addr  = tab_addr[idx];
                    bus.ent_mask  = tab_mask[idx];
                    bus.ent_data  = tab_data[idx];
                    bus.ent_last  = (idx == n - 1);
                end else begin
                    gap_cnt--;
                end
            end
            if (bus.ent_valid && bus.ent_ready) pending = 1;
            if (bus.ent_ready !== (dbg_state == S_FETCH)) sq_ready_viol++;
            if (!seen_den) begin
                if (bus.pll_den) begin
                    seen_den = 1;
                    sq_den_cyc = cyc;
                end else if (bus.pll_rst) begin
                    sq_rst_hold++;
                end
            end
            if (sq_rel_cyc < 0 && busy && !bus.pll_rst) sq_rel_cyc = cyc;
            if (done) sq_done = 1;
            if (error) begin
                sq_err = 1;
                sq_err_cyc = cyc;
            end
            if (sq_done || sq_err) break;
            @(negedge dclk);
        end
        bus.ent_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        bus.ent_valid = 1'b0;
        bus.ent_addr = '0; bus.ent_mask = '0; bus.ent_data = '0; bus.ent_last = 1'b0;
        repeat (3) @(negedge dclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
        checks++; if (bus.ent_ready !== 1'b0) begin errors++; $display("FAIL reset_ent_ready: got %b want 0", bus.ent_ready); end
        checks++; if ({bus.pll_den, bus.pll_dwe} !== 2'b00) begin errors++; $display("FAIL reset_den_dwe: got %b want 00", {bus.pll_den, bus.pll_dwe}); end
        checks++; if ({bus.pll_daddr, bus.pll_di} !== 23'd0) begin errors++; $display("FAIL reset_addr_di: got %h want 0", {bus.pll_daddr, bus.pll_di}); end
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL reset_pll_rst: got %b want 1", bus.pll_rst); end
        rst_n = 1'b1;
        @(negedge dclk);
    endtask

    task automatic test_single_entry;
        int base;
        preload(7'h08, 16'h1C00);
        base = wr_q.size();
        exp_q.delete();
        exp_q.push_back({7'h08, 16'h1041});
        tab_addr[0] = 7'h08; tab_mask[0] = 16'h0FFF; tab_data[0] = 16'h0041;
        run_seq(1, 0, 200);
        checks++; if (sq_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", sq_done); end
        checks++; if (sq_rst_hold < 4) begin errors++; $display("FAIL single_rst_hold: got %0d cycles want >=4", sq_rst_hold); end
        checks++; if (sq_rel_cyc < 0) begin errors++; $display("FAIL single_rst_release: got %0d want >=0", sq_rel_cyc); end
        checks++; if (wr_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL single_wr_count: got %0d want %0d", wr_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < wr_q.size(); i++) begin
            checks++; if (wr_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL single_wr%0d: got %h want %h", i, wr_q[base + i], exp_q[i]); end
        end
        @(negedge dclk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", busy); end
        checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL single_rst_after_lock: got %b want 0", bus.pll_rst); end
    endtask

    task automatic test_three_entries;
        int base, rd_base, exp_rd;
        preload(7'h08, 16'hAAAA);
        preload(7'h09, 16'h0000);
        preload(7'h14, 16'hFFFF);
        base = wr_q.size();
        rd_base = rd_count;
        exp_q.delete();
        exp_q.push_back({7'h08, 16'hAA34});
        exp_q.push_back({7'h09, 16'hBEEF});
        exp_q.push_back({7'h14, 16'h0F0F});
`ifdef PLL_DRP_VERIFY_EN
        exp_rd = 6;
`else
        exp_rd = 3;
`endif
        tab_addr[0] = 7'h08; tab_mask[0] = 16'h00FF; tab_data[0] = 16'h1234;
        tab_addr[1] = 7'h09; tab_mask[1] = 16'hFFFF; tab_data[1] = 16'hBEEF;
        tab_addr[2] = 7'h14; tab_mask[2] = 16'hF0F0; tab_data[2] = 16'h0000;
        run_seq(3, 3, 400);
        checks++; if (sq_done !== 1'b1) begin errors++; $display("FAIL three_done: got %b want 1", sq_done); end
        checks++; if (sq_ready_viol !== 0) begin errors++; $display("FAIL three_ready_only_fetch: got %0d bad cycles want 0", sq_ready_viol); end
        checks++; if (rd_count - rd_base !== exp_rd) begin errors++; $display("FAIL three_rd_count: got %0d want %0d", rd_count - rd_base, exp_rd); end
        checks++; if (wr_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL three_wr_count: got %0d want %0d", wr_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < wr_q.size(); i++) begin
            checks++; if (wr_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL three_wr%0d: got %h want %h", i, wr_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_drdy_timeout;
        drp_mode = 1;
        tab_addr[0] = 7'h0A; tab_mask[0] = 16'h0000; tab_data[0] = 16'h0000;
        run_seq(1, 0, 300);
        checks++; if (sq_err !== 1'b1) begin errors++; $display("FAIL drdy_to_error: got %b want 1", sq_err); end
        checks++; if (err_code !== ERR_DRDY) begin errors++; $display("FAIL drdy_to_code: got %0d want 1", err_code); end
        checks++; if (sq_err_cyc - sq_den_cyc < 64 || sq_err_cyc - sq_den_cyc > 70) begin
            errors++; $display("FAIL drdy_to_latency: got %0d cycles want 64..70", sq_err_cyc - sq_den_cyc); end
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL drdy_to_pll_rst: got %b want 1", bus.pll_rst); end
        @(negedge dclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drdy_to_busy_fall: got %b want 0", busy); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL drdy_to_sticky: got %b want 1", error); end
        drp_mode = 0;
        run_seq(1, 0, 200);
        checks++; if (sq_err_at_start !== 1'b0) begin errors++; $display("FAIL retry_clears_error: got %b want 0", sq_err_at_start); end
        checks++; if (sq_done !== 1'b1) begin errors++; $display("FAIL retry_done: got %b want 1", sq_done); end
    endtask

    task automatic test_lock_timeout;
        lock_en = 1'b0;
        tab_addr[0] = 7'h0B; tab_mask[0] = 16'h00F0; tab_data[0] = 16'h0050;
        run_seq(1, 0, 6000);
        checks++; if (sq_err !== 1'b1) begin errors++; $display("FAIL lock_to_error: got %b want 1", sq_err); end
        checks++; if (err_code !== ERR_LOCK) begin errors++; $display("FAIL lock_to_code: got %0d want 2", err_code); end
        checks++; if (sq_err_cyc - sq_rel_cyc < 4096 || sq_err_cyc - sq_rel_cyc > 4100) begin
            errors++; $display("FAIL lock_to_latency: got %0d cycles want 4096..4100", sq_err_cyc - sq_rel_cyc); end
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL lock_to_pll_rst: got %b want 1", bus.pll_rst); end
        lock_en = 1'b1;
        @(negedge dclk);
    endtask

    task automatic test_reset_mid_seq;
        bit reached;
        int done_cnt, busy_cnt;
        reached = 0; done_cnt = 0; busy_cnt = 0;
        preload(7'h30, 16'h5555);
        drp_mode = 2;
        @(negedge dclk);
        start = 1'b1;
        @(negedge dclk);
        start = 1'b0;
        bus.ent_valid = 1'b1; bus.ent_addr = 7'h30; bus.ent_mask = 16'hFFFF;
        bus.ent_data = 16'h1234; bus.ent_last = 1'b1;
        for (int i = 0; i < 20 && !bus.ent_ready; i++) @(negedge dclk);
        @(negedge dclk);
        bus.ent_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dbg_state == S_WR_WAIT) begin
                reached = 1;
                break;
            end
            @(negedge dclk);
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL midrst_reach_wr_wait: got %b want 1", reached); end
        rst_n = 1'b0;
        @(negedge dclk);
        checks++; if ({busy, done, error, bus.ent_ready} !== 4'b0000) begin
            errors++; $display("FAIL midrst_flags: got %b want 0000", {busy, done, error, bus.ent_ready}); end
        checks++; if ({bus.pll_den, bus.pll_dwe, err_code} !== 4'b0000) begin
            errors++; $display("FAIL midrst_drp_code: got %b want 0000", {bus.pll_den, bus.pll_dwe, err_code}); end
        checks++; if ({bus.pll_daddr, bus.pll_di} !== 23'd0) begin errors++; $display("FAIL midrst_addr_di: got %h want 0", {bus.pll_daddr, bus.pll_di}); end
        checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL midrst_pll_rst: got %b want 1", bus.pll_rst); end
        @(negedge dclk);
        rst_n = 1'b1;
        inject_drdy = 1'b1;
        @(negedge dclk);
        inject_drdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            @(negedge dclk);
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL midrst_stays_idle: got %0d busy cycles want 0", busy_cnt); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, S_IDLE); end
        drp_mode = 0;
    endtask

    task automatic test_verify;
        int base;
        preload(7'h08, 16'h1C00);
        corrupt = 1'b1;
        base = wr_q.size();
        exp_q.delete();
        exp_q.push_back({7'h08, 16'h1041});
        tab_addr[0] = 7'h08; tab_mask[0] = 16'h0FFF; tab_data[0] = 16'h0041;
        run_seq(1, 0, 200);
`ifdef PLL_DRP_VERIFY_EN
        checks++; if (sq_err !== 1'b1) begin errors++; $display("FAIL verify_error: got %b want 1", sq_err); end
        checks++; if (err_code !== ERR_VERIFY) begin errors++; $display("FAIL verify_code: got %0d want 3", err_code); end
`else
        checks++; if (sq_done !== 1'b1) begin errors++; $display("FAIL verify_off_done: got %b want 1", sq_done); end
        checks++; if (err_code !== ERR_NONE) begin errors++; $display("FAIL verify_off_code: got %0d want 0", err_code); end
`endif
        checks++; if (wr_q.size() - base !== 1) begin errors++; $display("FAIL verify_wr_count: got %0d want 1", wr_q.size() - base); end
        if (wr_q.size() > base) begin
            checks++; if (wr_q[base] !== exp_q[0]) begin errors++; $display("FAIL verify_wr: got %h want %h", wr_q[base], exp_q[0]); end
        end
        corrupt = 1'b0;
        @(negedge dclk);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_entry();
        test_three_entries();
        test_drdy_timeout();
        test_lock_timeout();
        test_reset_mid_seq();
        test_verify();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
